// File: rtl/nonce_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nonce_hub_pkg
// Description : Shared types and helpers for the nonce hub: nonce word type,
//               transmit FSM state encoding and a constant-foldable clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package nonce_hub_pkg;

  typedef logic [31:0] nonce_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } tx_state_e;

  // Ceiling log2; clog2(1) is 0. Bounded loop so it folds at elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_hub_if.sv
`default_nettype none
// ============================================================================
// Module      : nonce_hub_if
// Description : Bundle of miner-side, transmitter-side and status signals of
//               the nonce hub. 'slave' is the hub's view, 'master' the
//               environment's view (miners plus serial transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
interface nonce_hub_if #(
  parameter int SLAVES = 2,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) ();
  import nonce_hub_pkg::*;

  localparam int IDW   = (clog2(SLAVES) < 1) ? 1 : clog2(SLAVES);
  localparam int LVL_W = clog2(DEPTH) + 1;

  logic [SLAVES*32-1:0] slave_nonces;
  logic [SLAVES-1:0]    new_nonces;
  logic                 flush;
  logic                 serial_busy;
  logic                 serial_send;
  logic [31:0]          golden_nonce;
  logic [IDW-1:0]       golden_id;
  logic [LVL_W-1:0]     fifo_level;
  logic [DROP_W-1:0]    drop_count;
  logic                 hub_busy;

  modport master (
    output slave_nonces, new_nonces, flush, serial_busy,
    input  serial_send, golden_nonce, golden_id, fifo_level, drop_count, hub_busy
  );

  modport slave (
    input  slave_nonces, new_nonces, flush, serial_busy,
    output serial_send, golden_nonce, golden_id, fifo_level, drop_count, hub_busy
  );

endinterface
`default_nettype wire

// File: rtl/nonce_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nonce_fifo
// Description : Synchronous power-of-two FIFO with fall-through read data,
//               synchronous clear and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_fifo
  import nonce_hub_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             w_wr;
  logic             w_rd;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Clear wins over any access in the same cycle.
  assign w_wr = wr_en & ~full & ~clear;
  assign w_rd = rd_en & ~empty & ~clear;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nonce_hub.sv
`default_nettype none
// ============================================================================
// Module      : nonce_hub
// Description : Collects golden nonces from SLAVES miners into per-slave
//               pending slots, arbitrates them round-robin into a FIFO and
//               drains the FIFO one word at a time to a serial transmitter.
//               Supports flush on new work and saturating drop accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_hub
  import nonce_hub_pkg::*;
#(
  parameter int SLAVES       = 2,
  parameter int DEPTH        = 8,
  parameter int DROP_W       = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  nonce_hub_if.slave  bus
);

  localparam int IDW   = (clog2(SLAVES) < 1) ? 1 : clog2(SLAVES);
  localparam int LVL_W = clog2(DEPTH) + 1;
  localparam int FW    = 32 + IDW;
  localparam int TW    = (clog2(BUSY_TIMEOUT + 1) < 1) ? 1 : clog2(BUSY_TIMEOUT + 1);

  // Capture / arbitration state
  logic [SLAVES-1:0] pending_q, pending_d;
  nonce_t            pend_val_q [SLAVES];
  nonce_t            pend_val_d [SLAVES];
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // Transmit state
  tx_state_e         state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  nonce_t            gold_nonce_q, gold_nonce_d;
  logic [IDW-1:0]    gold_id_q, gold_id_d;

  // Combinational wires
  logic              w_grant_vld;
  logic [IDW-1:0]    w_grant_idx;
  logic              w_push;
  logic [SLAVES-1:0] w_grant_vec;
  logic [FW-1:0]     w_push_data;
  logic [FW-1:0]     w_rd_data;
  logic              w_pop;
  logic              w_send;
  logic              w_full;
  logic              w_empty;
  logic [LVL_W-1:0]  w_level;

  // Round-robin search: lowest pending index at or after rr_ptr, wrapping.
  always_comb begin
    int             scan;
    logic [IDW-1:0] sidx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < SLAVES; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= SLAVES) scan = scan - SLAVES;
      sidx = IDW'(scan);
      if (!w_grant_vld && pending_q[sidx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = sidx;
      end
    end
  end

  // A flush cycle never pushes; the FIFO being cleared must stay empty.
  assign w_push      = w_grant_vld & ~w_full & ~bus.flush;
  assign w_grant_vec = w_push ? (SLAVES'(1) << w_grant_idx) : '0;
  assign w_push_data = {w_grant_idx, pend_val_q[w_grant_idx]};

  // Next round-robin pointer: one past the slave just served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_push) begin
      if (int'(w_grant_idx) == SLAVES - 1) rr_ptr_d = '0;
      else                                 rr_ptr_d = w_grant_idx + IDW'(1);
    end
  end

  // Capture strobes into pending slots; count overwrites of unserved values.
  always_comb begin
    pending_d  = pending_q;
    pend_val_d = pend_val_q;
    drop_d     = drop_q;
    for (int i = 0; i < SLAVES; i++) begin
      if (bus.new_nonces[i]) begin
        pend_val_d[i] = bus.slave_nonces[i*32 +: 32];
        pending_d[i]  = 1'b1;
        // Overwriting a value that was neither pushed nor flushed loses it.
        if (pending_q[i] && !w_grant_vec[i] && !bus.flush && (drop_d != '1))
          drop_d = drop_d + DROP_W'(1);
      end else if (bus.flush || w_grant_vec[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Capture and arbitration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      drop_q    <= '0;
      for (int i = 0; i < SLAVES; i++) pend_val_q[i] <= '0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_q     <= drop_d;
      pend_val_q <= pend_val_d;
    end
  end

  nonce_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.flush),
    .wr_en   (w_push),
    .wr_data (w_push_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  // Transmit FSM next-state: pop, pulse send, then track one busy episode.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    gold_nonce_d = gold_nonce_q;
    gold_id_d    = gold_id_q;
    w_pop        = 1'b0;
    w_send       = 1'b0;
    case (state_q)
      IDLE: begin
        // Popping during a flush would transmit stale work.
        if (!w_empty && !bus.serial_busy && !bus.flush) begin
          w_pop        = 1'b1;
          gold_nonce_d = w_rd_data[31:0];
          gold_id_d    = w_rd_data[FW-1:32];
          state_d      = LOAD;
        end
      end
      LOAD: begin
        w_send  = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (bus.serial_busy) begin
          state_d = WAIT_FALL;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged; the word is considered sent.
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_FALL: begin
        if (!bus.serial_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit FSM registers and the word presented to the transmitter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      gold_nonce_q <= '0;
      gold_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      gold_nonce_q <= gold_nonce_d;
      gold_id_q    <= gold_id_d;
    end
  end

  assign bus.serial_send  = w_send;
  assign bus.golden_nonce = gold_nonce_q;
  assign bus.golden_id    = gold_id_q;
  assign bus.fifo_level   = w_level;
  assign bus.drop_count   = drop_q;
  assign bus.hub_busy     = (|pending_q) | ~w_empty | (state_q != IDLE);

endmodule
`default_nettype wire
